// File: rtl/wf_edge_detector.sv
`default_nettype none
// ============================================================================
//  Module   : wf_edge_detector
//  Purpose  : Rescales smoothed 16-bit sums (filter gain removed by SHIFT) to
//             the 10-bit sample domain and reports rising waveform edges found
//             with a first-difference threshold and a post-edge hold-off.
//  Ports    : clk, reset        - clock, synchronous active-high reset
//             i_valid           - i_sum carries a sample this cycle
//             i_sum [15:0]      - smoothed sum (unsigned)
//             i_last            - final sample of frame (qualified by i_valid)
//             i_thresh [9:0]    - minimum per-sample rise that arms (0 -> 1)
//             o_wf              - one-cycle edge pulse
//             o_idx [11:0]      - sample index where the rise began
//             o_amp [9:0]       - peak scaled amplitude of the rise
//             o_done            - one-cycle frame-complete pulse
//             o_count [7:0]     - edges in current frame (saturating)
//             o_busy            - frame in progress
//  Revision : 1.0 - initial release
// ============================================================================
module wf_edge_detector #(
  parameter int N_SAMPLES = 2400,
  parameter int SHIFT     = 6,
  parameter int HOLDOFF   = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_valid,
  input  logic [15:0] i_sum,
  input  logic        i_last,
  input  logic [9:0]  i_thresh,
  output logic        o_wf,
  output logic [11:0] o_idx,
  output logic [9:0]  o_amp,
  output logic        o_done,
  output logic [7:0]  o_count,
  output logic        o_busy
);

  localparam int              c_HW        = (HOLDOFF < 1) ? 1 : $clog2(HOLDOFF + 1);
  localparam logic [11:0]     c_LAST_IDX  = 12'(N_SAMPLES - 1);
  localparam logic [c_HW-1:0] c_HOLD_LOAD = c_HW'(HOLDOFF);
  localparam logic [c_HW-1:0] c_HOLD_ONE  = c_HW'(1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ARMED   = 2'd1,
    S_RISING  = 2'd2,
    S_HOLDOFF = 2'd3
  } state_t;

  state_t            r_state, w_state_nxt;
  logic [c_HW-1:0]   r_hold, w_hold_nxt;
  logic [11:0]       r_idx;          // index of the sample being presented
  logic [11:0]       r_idx_lat, w_idx_lat_nxt;
  logic [9:0]        r_peak, w_peak_nxt;
  logic [9:0]        r_y_prev;
  logic [7:0]        r_count, w_cnt_nxt;
  logic              r_wf, r_done, r_busy;
  logic [11:0]       r_o_idx;
  logic [9:0]        r_o_amp;
  logic              w_emit, w_done;

  // Scaling with saturation of anything that does not fit in 10 bits
  logic [15:0]        w_shifted;
  logic [9:0]         w_y;
  logic [9:0]         w_thr;
  logic signed [10:0] w_diff;
  logic               w_arm, w_rise, w_last;
  logic [9:0]         w_peak_max;

  assign w_shifted  = i_sum >> SHIFT;
  assign w_y        = (|w_shifted[15:10]) ? 10'd1023 : w_shifted[9:0];
  assign w_thr      = (i_thresh == 10'd0) ? 10'd1 : i_thresh;
  // The first sample of a frame (IDLE) has no predecessor, so its difference is 0
  assign w_diff     = (r_state == S_IDLE) ? 11'sd0
                    : $signed({1'b0, w_y}) - $signed({1'b0, r_y_prev});
  assign w_arm      = (w_diff >= $signed({1'b0, w_thr}));
  assign w_rise     = (w_diff > 11'sd0);
  assign w_last     = i_last | (r_idx == c_LAST_IDX);
  assign w_peak_max = (w_y > r_peak) ? w_y : r_peak;

  // Next-state logic; only committed on i_valid cycles
  always_comb begin
    w_state_nxt   = r_state;
    w_hold_nxt    = r_hold;
    w_idx_lat_nxt = r_idx_lat;
    w_peak_nxt    = r_peak;
    w_emit        = 1'b0;
    w_done        = 1'b0;

    case (r_state)
      S_IDLE: begin
        w_state_nxt = S_ARMED;
      end
      S_ARMED: begin
        if (w_arm) begin
          w_state_nxt   = S_RISING;
          w_idx_lat_nxt = r_idx;
          w_peak_nxt    = w_y;
        end
      end
      S_RISING: begin
        if (w_rise) begin
          w_peak_nxt = w_peak_max;
        end else begin
          w_emit = 1'b1;
          if (HOLDOFF == 0) begin
            w_state_nxt = S_ARMED;
          end else begin
            w_state_nxt = S_HOLDOFF;
            w_hold_nxt  = c_HOLD_LOAD;
          end
        end
      end
      S_HOLDOFF: begin
        w_hold_nxt = r_hold - c_HOLD_ONE;
        // The sample that brings the counter to zero is not evaluated
        if (r_hold == c_HOLD_ONE) begin
          w_state_nxt = S_ARMED;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase

    // Frame end overrides everything. A rise still open is closed here with
    // the last sample folded into its peak. A rise that would only begin on
    // the last sample has no extent and is not reported.
    if (w_last) begin
      if (r_state == S_RISING && !w_emit) begin
        w_emit     = 1'b1;
        w_peak_nxt = w_peak_max;
      end
      w_done      = 1'b1;
      w_state_nxt = S_IDLE;
      w_hold_nxt  = '0;
    end
  end

  assign w_cnt_nxt = (r_state == S_IDLE)              ? 8'd0
                   : (w_emit && (r_count != 8'hFF))   ? r_count + 8'd1
                   : r_count;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_hold    <= '0;
      r_idx     <= '0;
      r_idx_lat <= '0;
      r_peak    <= '0;
      r_y_prev  <= '0;
      r_count   <= '0;
      r_wf      <= 1'b0;
      r_done    <= 1'b0;
      r_busy    <= 1'b0;
      r_o_idx   <= '0;
      r_o_amp   <= '0;
    end else begin
      r_wf   <= 1'b0;
      r_done <= 1'b0;
      if (i_valid) begin
        r_state   <= w_state_nxt;
        r_hold    <= w_hold_nxt;
        r_idx_lat <= w_idx_lat_nxt;
        r_peak    <= w_peak_nxt;
        r_idx     <= w_last ? 12'd0 : r_idx + 12'd1;
        r_y_prev  <= w_last ? 10'd0 : w_y;
        r_count   <= w_cnt_nxt;
        r_wf      <= w_emit;
        r_done    <= w_done;
        r_busy    <= ~w_done;
        if (w_emit) begin
          r_o_idx <= r_idx_lat;
          r_o_amp <= w_peak_nxt;
        end
      end
    end
  end

  assign o_wf    = r_wf;
  assign o_idx   = r_o_idx;
  assign o_amp   = r_o_amp;
  assign o_done  = r_done;
  assign o_count = r_count;
  assign o_busy  = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_wf_edge_detector.sv
`default_nettype none
// ============================================================================
//  Module   : tb_wf_edge_detector
//  Purpose  : Self-checking bench for wf_edge_detector. Frames are described
//             as arrays of samples; a frame-level reference model scans the
//             whole array to list expected edges, then the frame is streamed
//             with optional valid gaps and every output is checked per cycle.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_wf_edge_detector;
  localparam int N  = 2400;
  localparam int SH = 6;
  localparam int HO = 16;

  logic        clk = 1'b0;
  logic        reset;
  logic        i_valid;
  logic [15:0] i_sum;
  logic        i_last;
  logic [9:0]  i_thresh;
  logic        o_wf;
  logic [11:0] o_idx;
  logic [9:0]  o_amp;
  logic        o_done;
  logic [7:0]  o_count;
  logic        o_busy;

  wf_edge_detector #(.N_SAMPLES(N), .SHIFT(SH), .HOLDOFF(HO)) dut (
    .clk(clk), .reset(reset), .i_valid(i_valid), .i_sum(i_sum),
    .i_last(i_last), .i_thresh(i_thresh), .o_wf(o_wf), .o_idx(o_idx),
    .o_amp(o_amp), .o_done(o_done), .o_count(o_count), .o_busy(o_busy)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Frame description
  int fs[N];      // raw sums
  int ft[N];      // thresholds
  int fy[N];      // scaled samples
  int flen;
  // Expected per accepted sample
  bit ewf[N];
  int eidx[N];
  int eamp[N];
  int ecnt[N];
  // Expected held output values
  int h_idx, h_amp, h_cnt;
  bit h_busy;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_outs(input string tag, input bit wf, input bit done);
    chk({tag, ".wf"},    32'(o_wf),    32'(wf));
    chk({tag, ".done"},  32'(o_done),  32'(done));
    chk({tag, ".idx"},   32'(o_idx),   32'(h_idx));
    chk({tag, ".amp"},   32'(o_amp),   32'(h_amp));
    chk({tag, ".count"}, 32'(o_count), 32'(h_cnt));
    chk({tag, ".busy"},  32'(o_busy),  32'(h_busy));
  endtask

  // Reference model over the whole frame: arming at i needs y[i]-y[i-1] >= thr;
  // the rise extends while samples keep increasing and closes on the first
  // non-increasing sample or the last sample; the HO samples after the
  // closing one are ignored.
  function automatic void model();
    int i, j, start, peak, th, c;
    for (int k = 0; k < flen; k++) begin
      fy[k]  = (fs[k] / 64 > 1023) ? 1023 : fs[k] / 64;
      ewf[k] = 1'b0;
    end
    i = 1;
    while (i < flen) begin
      th = (ft[i] == 0) ? 1 : ft[i];
      if ((fy[i] - fy[i-1] >= th) && (i != flen - 1)) begin
        start = i;
        peak  = fy[i];
        j     = i + 1;
        forever begin
          if (fy[j] > peak) peak = fy[j];
          if (j == flen - 1 || fy[j] <= fy[j-1]) break;
          j++;
        end
        ewf[j]  = 1'b1;
        eidx[j] = start;
        eamp[j] = peak;
        i = j + HO + 1;
      end else begin
        i++;
      end
    end
    c = 0;
    for (int k = 0; k < flen; k++) begin
      if (ewf[k] && c < 255) c++;
      ecnt[k] = c;
    end
  endfunction

  function automatic void set_y(input int k, input int y);
    fs[k] = y * 64 + int'($urandom_range(0, 63));
  endfunction

  function automatic void flat(input int len, input int base, input int thr);
    flen = len;
    for (int k = 0; k < len; k++) begin
      set_y(k, base);
      ft[k] = thr;
    end
  endfunction

  // Five steps of +20 above base starting at s, then base+50 to frame end
  function automatic void ramp(input int s, input int base);
    for (int k = 0; k < 5; k++) set_y(s + k, base + 20 * (k + 1));
    for (int k = s + 5; k < flen; k++) set_y(k, base + 50);
  endfunction

  task automatic idle_cycle(input string tag);
    i_valid  = 1'b0;
    i_sum    = 16'($urandom);
    i_last   = 1'($urandom);
    i_thresh = 10'($urandom);
    step();
    check_outs(tag, 1'b0, 1'b0);
  endtask

  // Streams the current frame; abort_at < flen stops early (for a reset)
  task automatic run_frame(input string tag, input bit use_last, input int gap_pct,
                           input int abort_at);
    bit is_last;
    model();
    for (int k = 0; k < flen && k < abort_at; k++) begin
      while (int'($urandom_range(0, 99)) < gap_pct) idle_cycle({tag, ".gap"});
      is_last  = (k == flen - 1);
      i_valid  = 1'b1;
      i_sum    = 16'(fs[k]);
      i_last   = use_last && is_last;
      i_thresh = 10'(ft[k]);
      step();
      if (ewf[k]) begin
        h_idx = eidx[k];
        h_amp = eamp[k];
      end
      h_cnt  = ecnt[k];
      h_busy = !is_last;
      check_outs(tag, ewf[k], is_last);
    end
    i_valid = 1'b0;
    if (abort_at >= flen) begin
      idle_cycle({tag, ".post"});
      chk({tag, ".final_count"}, 32'(o_count), 32'(ecnt[flen-1]));
    end
  endtask

  task automatic do_reset(input string tag);
    reset   = 1'b1;
    i_valid = 1'b1;
    i_sum   = 16'($urandom);
    i_last  = 1'b0;
    step();
    reset  = 1'b0;
    h_idx  = 0;
    h_amp  = 0;
    h_cnt  = 0;
    h_busy = 1'b0;
    check_outs(tag, 1'b0, 1'b0);
    idle_cycle({tag, ".after"});
  endtask

  initial begin
    int y;
    reset    = 1'b1;
    i_valid  = 1'b0;
    i_sum    = '0;
    i_last   = 1'b0;
    i_thresh = '0;
    h_idx = 0; h_amp = 0; h_cnt = 0; h_busy = 1'b0;
    repeat (3) step();
    check_outs("reset", 1'b0, 1'b0);
    reset = 1'b0;
    idle_cycle("idle");

    flat(N, 100, 5);
    run_frame("flat", 1'b1, 0, N);

    flat(50, 100, 10); ramp(10, 100);
    run_frame("ramp", 1'b1, 0, N);
    chk("ramp.edge_idx", 32'(o_idx), 32'd10);
    chk("ramp.edge_amp", 32'(o_amp), 32'd200);
    chk("ramp.count1",   32'(o_count), 32'd1);

    flat(60, 100, 10); ramp(10, 100); ramp(20, 150);
    run_frame("hold_a", 1'b1, 0, N);
    chk("hold_a.count", 32'(o_count), 32'd1);

    flat(60, 100, 10); ramp(10, 100); ramp(40, 150);
    run_frame("hold_b", 1'b1, 0, N);
    chk("hold_b.idx2",  32'(o_idx),   32'd40);
    chk("hold_b.count", 32'(o_count), 32'd2);

    flat(50, 100, 5);
    for (int k = 0; k < 5; k++) set_y(45 + k, 110 + 10 * k);
    run_frame("rise_end", 1'b1, 0, N);
    chk("rise_end.idx", 32'(o_idx), 32'd45);

    flat(20, 100, 10);
    fs[10] = 16'hFFFF;
    run_frame("sat", 1'b1, 0, N);
    chk("sat.amp", 32'(o_amp), 32'd1023);

    flat(100, 300, 0);
    run_frame("thr0", 1'b1, 0, N);

    flat(N, 100, 10); ramp(100, 100);
    run_frame("overrun", 1'b0, 0, N);
    flat(50, 100, 10); ramp(10, 100);
    run_frame("restart", 1'b1, 0, N);
    chk("restart.idx", 32'(o_idx), 32'd10);

    flat(1000, 100, 10); ramp(10, 100); ramp(696, 150);
    run_frame("pre_reset", 1'b1, 0, 700);
    do_reset("midreset");
    flat(50, 100, 10); ramp(10, 100);
    run_frame("post_reset", 1'b1, 0, N);

    flat(50, 100, 10); ramp(10, 100);
    run_frame("gaps", 1'b1, 40, N);
    chk("gaps.idx", 32'(o_idx), 32'd10);
    chk("gaps.amp", 32'(o_amp), 32'd200);

    for (int f = 0; f < 6; f++) begin
      flen = int'($urandom_range(20, 300));
      y = 400;
      for (int k = 0; k < flen; k++) begin
        y = y + int'($urandom_range(0, 80)) - 38;
        if (y < 0) y = 0;
        if (y > 1100) y = 1100;
        fs[k] = (y * 64 > 65535) ? 65535 : y * 64 + int'($urandom_range(0, 63));
        if (fs[k] > 65535) fs[k] = 65535;
        ft[k] = int'($urandom_range(0, 40));
      end
      run_frame("rand", 1'b1, 20, N);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire

// File: doc/wf_edge_detector.md
# wf_edge_detector

Downstream consumer of the 15-tap triangular smoothing stage (weights 1..8..1, gain 64). Accepts one 16-bit smoothed sum per valid cycle for a frame of up to 2400 samples, rescales it to the 10-bit sample domain, and detects rising waveform edges using a first-difference threshold with a hold-off window. For each detected edge it reports a one-cycle `o_wf` pulse with start index and peak amplitude. It reports the edge count at frame end.

## Interface
- `N_SAMPLES`, 2400, maximum samples per frame
- `SHIFT`, 6, right shift removing the filter gain (sum of weights = 64)
- `HOLDOFF`, 16, valid samples ignored after each reported edge
- `clk` input 1, rising-edge clock
- `reset` input 1, synchronous, active-high; clears all state and outputs
- `i_valid` input 1, `i_sum` carries a sample this cycle
- `i_sum` input 16, smoothed sum from the filter stage (unsigned)
- `i_last` input 1, qualifies the final sample of the frame; ignored unless `i_valid`=1
- `i_thresh` input 10, minimum rise per sample that arms an edge; value 0 is treated as 1
- `o_wf` output 1, one-cycle pulse: edge detected
- `o_idx` output 12, sample index where the rise began; valid with `o_wf`, otherwise held
- `o_amp` output 10, peak scaled amplitude of the rise; valid with `o_wf`, otherwise held
- `o_done` output 1, one-cycle pulse: frame complete
- `o_count` output 8, edges in the current frame; saturates at 255; cleared at the first sample of the next frame
- `o_busy` output 1, high from the first accepted sample of a frame until `o_done`

## Operation
- Scaling: `y = i_sum >> SHIFT`. If any bit above bit 9 of the shifted value is set, `y` saturates to 1023.
- Difference: `d = y - y_prev`, signed 11-bit. At frame index 0, `d = 0`.
- Sample index: counts accepted samples from 0.
  - If index N_SAMPLES-1 is reached without `i_last`, that sample is treated as last.
- FSM states and transitions (all evaluated only on `i_valid` cycles):
  - IDLE: a valid sample moves the FSM to ARMED. This sample is index 0; `o_count` clears and `o_busy` rises.
  - ARMED: if `d >= thr` (where `thr` = max(`i_thresh`,1)), go to RISING. Latch `idx` = current index and `peak` = `y`.
  - RISING, `d > 0`: set `peak` = max(`peak`, `y`) and stay in RISING.
  - RISING, `d <= 0`: emit the edge (`o_wf`, `o_idx`=`idx`, `o_amp`=`peak`), increment `o_count`, load the hold-off counter with HOLDOFF, and go to HOLDOFF.
  - HOLDOFF: decrement on each valid sample. On reaching 0, go to ARMED. The sample that reaches 0 is not evaluated for arming.
- Frame end (last sample accepted, from any state):
  - If in RISING, fold the last sample into `peak` and emit the edge on the same output cycle.
  - Pulse `o_done`, then return to IDLE. The hold-off counter and `y_prev` are cleared.
- Edge emission and `o_done` may coincide in the same cycle. `o_count` then already includes that edge.
- HOLDOFF=0: the FSM passes from RISING directly to ARMED. Re-arming is evaluated from the next sample.
- `i_thresh` is sampled on each valid cycle; changes mid-frame take effect immediately.
- Reset mid-frame: the frame is abandoned with no `o_done`. The next valid sample starts a new frame at index 0.

## Timing
- All outputs are registered.
- `o_wf`, `o_idx`, `o_amp`, `o_count` update in the cycle after the clock edge that accepts the deciding sample (1-cycle latency).
- `o_done` follows the same 1-cycle latency after the last sample. `o_busy` falls in the cycle `o_done` is high.
- Gaps in `i_valid` stall the FSM and index; state is held.
- Throughput: one sample per clock.
- Reset values: `o_wf`=0, `o_idx`=0, `o_amp`=0, `o_done`=0, `o_count`=0, `o_busy`=0, FSM=IDLE.

## Test plan
- **Flat frame.** Stimulus: 2400 samples with `i_sum`=64·100, `i_thresh`=5, `i_last` on sample 2399. Required: no `o_wf`; `o_done` pulses once; `o_count`=0.
- **Single ramp.** Stimulus: `y` = 100 for indices 0–9, then rises 20/sample for indices 10–14 to 200, then 150 thereafter; frame of 50 samples, `i_thresh`=10. Required: one `o_wf` one cycle after index 15 is accepted, with `o_idx`=10, `o_amp`=200; `o_count`=1.
- **Hold-off.** Stimulus: two ramps as above starting at indices 10 and 20, HOLDOFF=16. Required: only the first is reported. Repeat with the second ramp starting at index 40: two reports, `o_idx`=10 and 40.
- **Edge cases.**
  - A rise still in progress at `i_last` (index 49), rising from index 45. Required: `o_wf` and `o_done` in the same cycle, `o_idx`=45.
  - `i_sum`=16'hFFFF. Required: `y` saturates to 1023.
  - `i_thresh`=0 on a flat frame. Required: no edges.
- **Overrun and reset.**
  - 2400 samples with no `i_last`. Required: `o_done` after index 2399; the next sample restarts at index 0.
  - `reset` asserted at index 700. Required: all outputs return to 0, no `o_done`; the next frame is processed normally.
- **Valid gaps.** Stimulus: the single-ramp test with random `i_valid` deassertion. Required: results identical to the gap-free run.
